comb_eval: RTL and testbench
============================

COMB_EVAL -- requirements
Module: comb_eval

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the saturating mismatch counter.
REQ-002 clk  input  1  rising-edge clock; all registers SHALL be clocked on this edge.
REQ-003 rst  input  1  reset, synchronous and active-high; one clock drives the block.
REQ-004 a  input  1  function input, MSB of index n = 8a+4b+2c+d.
REQ-005 b  input  1  function input, weight 4.
REQ-006 c  input  1  function input, weight 2.
REQ-007 d  input  1  function input, LSB, weight 1.
REQ-008 f_behavior  output  1  combinational F, behavioural implementation.
REQ-009 f_dataflow  output  1  combinational F, continuous-assignment implementation.
REQ-010 f_prim  output  1  combinational F, gate-primitive implementation.
REQ-011 f_q  output  1  registered F.
REQ-012 mismatch_q  output  1  registered flag: the three implementations disagreed.
REQ-013 err_cnt  output  CNT_W  count of clock cycles in which mismatch was detected.

Function
REQ-014 F SHALL equal 1 exactly for n in {1,3,4,6,9,12,14,15} and 0 for all other n.
REQ-015 The minimal sum-of-products form is F = b·~d + ~a·~b·d + ~b·~c·d + a·b·c.
REQ-016 f_behavior SHALL be computed in a combinational procedural block using a case on {a,b,c,d}, with a default branch of 0.
REQ-017 f_dataflow SHALL be computed as a single continuous assignment of the SOP in REQ-015.
REQ-018 f_prim SHALL be built only from not/and/or gate primitives that implement REQ-015.
REQ-019 The three combinational outputs SHALL have zero-cycle latency and SHALL be independent of clk and rst.
REQ-020 f_q SHALL load f_behavior on each rising clk edge, giving a latency of one cycle.
REQ-021 mismatch_q SHALL load (f_behavior != f_dataflow) | (f_behavior != f_prim) on each edge.
REQ-022 err_cnt SHALL increment by 1 on each edge where the combinational mismatch term is 1.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 An X or Z on any input SHALL NOT increment err_cnt; only known 0/1 disagreement counts.
REQ-025 Inputs SHALL be able to change every cycle or asynchronously; registered outputs sample the values settled at the clk edge.

Reset
REQ-026 While rst=1 at a clk edge, f_q, mismatch_q and err_cnt SHALL all become 0.
REQ-027 Reset SHALL take priority over counting and loading.
REQ-028 Combinational outputs SHALL remain valid during reset.
REQ-029 If reset is asserted mid-operation, the registers SHALL clear on the next edge.
REQ-030 Registered outputs SHALL resume normal behaviour on the first edge with rst=0.

Verification
REQ-031 Exhaustive sweep: {a,b,c,d} counts 0000..1111. Required: all three outputs read 0,1,0,1,1,0,1,0,0,1,0,0,1,0,1,1, and they agree at every step.
REQ-032 Settle check: apply n=15, then n=13. Required: all three outputs read 1 for n=15, then 0 for n=13.
REQ-033 Registered output: hold rst=1 for 2 cycles, then apply n=9 and clock once. Required: f_q=1, mismatch_q=0, err_cnt=0.
REQ-034 Reset mid-run: apply n=6, clock (f_q=1), then rst=1 and clock. Required: f_q=0 and err_cnt=0 while the combinational outputs stay 1.
REQ-035 Fault injection: force f_prim to its inverse for 3 cycles. Required: mismatch_q=1 during those cycles, err_cnt=3, then mismatch_q=0 one cycle after the force is released.
REQ-036 Saturation: with CNT_W=2, force a mismatch for 6 cycles. Required: err_cnt stops at 3.

Source files
------------

// File: rtl/comb_eval.sv
// comb_eval: evaluates the four-input function F three ways (behavioural case,
// continuous SOP assignment, gate primitives) and cross-checks them. F is 1
// for n = 8a+4b+2c+d in {1,3,4,6,9,12,14,15}.
//
// Ports
//   clk         rising-edge clock for all registers
//   rst         synchronous active-high reset
//   a, b, c, d  function inputs (a is the MSB of n)
//   f_behavior  F from a procedural case statement
//   f_dataflow  F from one continuous SOP assignment
//   f_prim      F from not/and/or primitives
//   f_q         f_behavior registered (one cycle latency)
//   mismatch_q  registered disagreement flag between the three forms
//   err_cnt     saturating count of cycles with a disagreement
module comb_eval #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic             f_behavior,
   output logic             f_dataflow,
   output logic             f_prim,
   output logic             f_q,
   output logic             mismatch_q,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             r_f_q;
   logic             r_mismatch;
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_mismatch;

   wire w_na, w_nb, w_nc, w_nd;
   wire w_p0, w_p1, w_p2, w_p3;
   wire w_prim;

   always_comb begin
      f_behavior = 1'b0;
      case ({a, b, c, d})
         4'd1, 4'd3, 4'd4, 4'd6, 4'd9, 4'd12, 4'd14, 4'd15: f_behavior = 1'b1;
         default: f_behavior = 1'b0;
      endcase
   end

   assign f_dataflow = (b & ~d) | (~a & ~b & d) | (~b & ~c & d) | (a & b & c);

   not u_na (w_na, a);
   not u_nb (w_nb, b);
   not u_nc (w_nc, c);
   not u_nd (w_nd, d);
   and u_p0 (w_p0, b, w_nd);
   and u_p1 (w_p1, w_na, w_nb, d);
   and u_p2 (w_p2, w_nb, w_nc, d);
   and u_p3 (w_p3, a, b, c);
   or  u_or (w_prim, w_p0, w_p1, w_p2, w_p3);

   assign f_prim = w_prim;

   assign w_mismatch = (f_behavior != f_dataflow) | (f_behavior != f_prim);

   // if/else rather than a direct load so an unknown mismatch term (X/Z on
   // the inputs) takes the else path: only a known disagreement sets the
   // flag or advances the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_f_q      <= 1'b0;
         r_mismatch <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_f_q <= f_behavior;
         if (w_mismatch) begin
            r_mismatch <= 1'b1;
            if (r_err_cnt != CNT_MAX) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
         end else begin
            r_mismatch <= 1'b0;
         end
      end
   end

   assign f_q        = r_f_q;
   assign mismatch_q = r_mismatch;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_comb_eval.sv
// Directed bench for comb_eval: exhaustive truth table, settle check, reset
// behaviour, fault injection by forcing the primitive path, and counter
// saturation on a second instance with a 2-bit counter.
module tb_comb_eval;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

   logic       f_beh, f_df, f_pr, f_q, mm_q;
   logic [7:0] err_cnt;
   logic       f_beh2, f_df2, f_pr2, f_q2, mm_q2;
   logic [1:0] err_cnt2;

   int checks = 0;
   int errors = 0;

   // bit n of this table is F(n)
   logic [15:0] exp_tab = 16'b1101_0010_0101_1010;

   always #5 clk = ~clk;

   comb_eval #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
      .f_behavior(f_beh), .f_dataflow(f_df), .f_prim(f_pr),
      .f_q(f_q), .mismatch_q(mm_q), .err_cnt(err_cnt)
   );

   comb_eval #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
      .f_behavior(f_beh2), .f_dataflow(f_df2), .f_prim(f_pr2),
      .f_q(f_q2), .mismatch_q(mm_q2), .err_cnt(err_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [3:0] n);
      {a, b, c, d} = n;
      #1;
   endtask

   initial begin
      // reset state
      apply(4'd0);
      tick();
      tick();
      check("rst_f_q", 32'(f_q), 32'd0);
      check("rst_mismatch_q", 32'(mm_q), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_err_cnt2", 32'(err_cnt2), 32'd0);
      // combinational outputs valid while in reset
      apply(4'd4);
      check("rst_comb_beh", 32'(f_beh), 32'd1);
      check("rst_comb_prim", 32'(f_pr), 32'd1);
      rst = 1'b0;

      // exhaustive sweep
      for (int n = 0; n < 16; n++) begin
         apply(4'(n));
         check($sformatf("sweep_beh_%0d", n), 32'(f_beh), 32'(exp_tab[n]));
         check($sformatf("sweep_df_%0d", n), 32'(f_df), 32'(exp_tab[n]));
         check($sformatf("sweep_prim_%0d", n), 32'(f_pr), 32'(exp_tab[n]));
         tick();
         check($sformatf("sweep_f_q_%0d", n), 32'(f_q), 32'(exp_tab[n]));
         check($sformatf("sweep_mm_%0d", n), 32'(mm_q), 32'd0);
      end
      check("sweep_err_cnt", 32'(err_cnt), 32'd0);

      // settle check
      apply(4'd15);
      check("settle15_beh", 32'(f_beh), 32'd1);
      check("settle15_df", 32'(f_df), 32'd1);
      check("settle15_prim", 32'(f_pr), 32'd1);
      apply(4'd13);
      check("settle13_beh", 32'(f_beh), 32'd0);
      check("settle13_df", 32'(f_df), 32'd0);
      check("settle13_prim", 32'(f_pr), 32'd0);

      // registered output after a 2-cycle reset
      rst = 1'b1;
      tick();
      tick();
      check("reset2_f_q", 32'(f_q), 32'd0);
      rst = 1'b0;
      apply(4'd9);
      tick();
      check("reg9_f_q", 32'(f_q), 32'd1);
      check("reg9_mm", 32'(mm_q), 32'd0);
      check("reg9_err", 32'(err_cnt), 32'd0);

      // reset mid-run
      apply(4'd6);
      tick();
      check("mid_f_q_before", 32'(f_q), 32'd1);
      rst = 1'b1;
      tick();
      check("mid_f_q_rst", 32'(f_q), 32'd0);
      check("mid_err_rst", 32'(err_cnt), 32'd0);
      check("mid_comb_beh", 32'(f_beh), 32'd1);
      check("mid_comb_df", 32'(f_df), 32'd1);
      check("mid_comb_prim", 32'(f_pr), 32'd1);
      rst = 1'b0;
      tick();
      check("resume_f_q", 32'(f_q), 32'd1);

      // fault injection on the main instance (F(9)=1, primitive path forced to 0)
      apply(4'd9);
      force dut.w_prim = 1'b0;
      #1;
      check("fault_prim_out", 32'(f_pr), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("fault_mm_%0d", k), 32'(mm_q), 32'd1);
         check($sformatf("fault_err_%0d", k), 32'(err_cnt), 32'(k));
      end
      release dut.w_prim;
      #1;
      tick();
      check("fault_release_mm", 32'(mm_q), 32'd0);
      check("fault_release_err", 32'(err_cnt), 32'd3);
      check("fault_other_inst_err", 32'(err_cnt2), 32'd0);

      // saturation on the 2-bit counter instance
      force dut2.w_prim = 1'b0;
      #1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("sat_err_%0d", k), 32'(err_cnt2), (k < 3) ? 32'(k) : 32'd3);
         check($sformatf("sat_mm_%0d", k), 32'(mm_q2), 32'd1);
      end
      release dut2.w_prim;
      #1;
      tick();
      check("sat_release_mm", 32'(mm_q2), 32'd0);
      check("sat_hold_err", 32'(err_cnt2), 32'd3);
      check("main_err_unchanged", 32'(err_cnt), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
